// File: rtl/cond_branch_unit_if.sv
// Bus bundle between the fetch/execute pipeline and the conditional branch unit.
// The master drives flags, lookup PC and resolving jumps; the slave (the branch
// unit) returns architectural flags, the prediction and the resolution results.
interface cond_branch_unit_if #(
  parameter int PC_W = 16
) ();

  logic            cpsr_we;
  logic [3:0]      cpsr_wdata;
  logic [3:0]      cpsr_out;
  logic [PC_W-1:0] pc_f;
  logic            pred_taken;
  logic            br_valid;
  logic [3:0]      br_cond;
  logic [PC_W-1:0] br_pc;
  logic            br_pred;
  logic            res_valid;
  logic            res_taken;
  logic            mispredict;
  logic [15:0]     br_count;
  logic [15:0]     mp_count;

  modport master (
    output cpsr_we, cpsr_wdata, pc_f, br_valid, br_cond, br_pc, br_pred,
    input  cpsr_out, pred_taken, res_valid, res_taken, mispredict, br_count, mp_count
  );

  modport slave (
    input  cpsr_we, cpsr_wdata, pc_f, br_valid, br_cond, br_pc, br_pred,
    output cpsr_out, pred_taken, res_valid, res_taken, mispredict, br_count, mp_count
  );

endinterface

// File: rtl/cond_branch_unit.sv
// Conditional branch unit: holds the {N,Z,C,V} flag register, evaluates jump
// conditions on forwarded flags, reports the outcome one cycle later and trains
// a table of 2-bit saturating predictors (0 SNT, 1 WNT, 2 WT, 3 ST).
module cond_branch_unit #(
  parameter int PC_W      = 16,
  parameter int BHT_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  cond_branch_unit_if.slave   bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [PC_W-1:0]  pc_f_w;
  logic [PC_W-1:0]  br_pc_w;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       eff_flags;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             cond_true;
  logic             outcome;
  logic             mp_now;
  logic [1:0]       bht [BHT_DEPTH];

  // Upper PC bits do not take part in indexing; aliasing PCs share a counter.
  logic unused_pc_bits;

  assign pc_f_w         = bus.pc_f;
  assign br_pc_w        = bus.br_pc;
  assign rd_idx         = pc_f_w[IDX_W-1:0];
  assign wr_idx         = br_pc_w[IDX_W-1:0];
  assign unused_pc_bits = &{1'b0, pc_f_w[PC_W-1:IDX_W], br_pc_w[PC_W-1:IDX_W]};

  // Same-cycle forwarding so a flag-setting op and a dependent jump can pair up.
  assign eff_flags = bus.cpsr_we ? bus.cpsr_wdata : bus.cpsr_out;
  assign {flag_n, flag_z, flag_c, flag_v} = eff_flags;

  // Condition code decode on the effective flags.
  always_comb begin
    cond_true = 1'b0;
    case (bus.br_cond)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = flag_z;
      4'd2:    cond_true = !flag_z;
      4'd3:    cond_true = (flag_n == flag_v);
      4'd4:    cond_true = !flag_z && (flag_n == flag_v);
      4'd5:    cond_true = flag_z || (flag_n != flag_v);
      4'd6:    cond_true = (flag_n != flag_v);
      4'd7:    cond_true = flag_c;
      4'd8:    cond_true = !flag_c;
      4'd9:    cond_true = flag_c && !flag_z;
      4'd10:   cond_true = !flag_c || flag_z;
      4'd11:   cond_true = flag_n;
      4'd12:   cond_true = !flag_n;
      4'd13:   cond_true = flag_v;
      4'd14:   cond_true = !flag_v;
      default: cond_true = 1'b0;
    endcase
  end

  assign outcome = bus.br_valid & cond_true;
  assign mp_now  = bus.br_valid & (outcome != bus.br_pred);

  // Lookup returns the stored value, so a same-cycle update shows up next cycle.
  assign bus.pred_taken = bht[rd_idx][1];

  // Architectural flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cpsr_out <= 4'b0000;
    end else if (bus.cpsr_we) begin
      bus.cpsr_out <= bus.cpsr_wdata;
    end
  end

  // One-cycle resolution results; cleared in cycles following no branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid  <= 1'b0;
      bus.res_taken  <= 1'b0;
      bus.mispredict <= 1'b0;
    end else begin
      bus.res_valid  <= bus.br_valid;
      bus.res_taken  <= outcome;
      bus.mispredict <= mp_now;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.br_count <= 16'h0000;
      bus.mp_count <= 16'h0000;
    end else begin
      if (bus.br_valid && (bus.br_count != 16'hFFFF)) begin
        bus.br_count <= bus.br_count + 16'h0001;
      end
      if (mp_now && (bus.mp_count != 16'hFFFF)) begin
        bus.mp_count <= bus.mp_count + 16'h0001;
      end
    end
  end

  // Predictor training: step the resolving jump's counter toward its outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'd1;
      end
    end else if (bus.br_valid) begin
      if (outcome && (bht[wr_idx] != 2'd3)) begin
        bht[wr_idx] <= bht[wr_idx] + 2'd1;
      end else if (!outcome && (bht[wr_idx] != 2'd0)) begin
        bht[wr_idx] <= bht[wr_idx] - 2'd1;
      end
    end
  end

endmodule

// File: doc/cond_branch_unit.md
COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 Parameter PC_W, default 16: width of the branch PC inputs.
REQ-002 Parameter BHT_DEPTH, default 16: number of 2-bit predictor counters; power of two and at least 2; IDX_W = log2(BHT_DEPTH).
REQ-003 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  in  1: reset, synchronous, active-high.
REQ-005 Port cpsr_we  in  1: flag write enable from the ALU.
REQ-006 Port cpsr_wdata  in  4: new flags {N,Z,C,V}, bit 3 = N.
REQ-007 Port cpsr_out  out  4: registered architectural flags {N,Z,C,V}.
REQ-008 Port pc_f  in  PC_W: fetch PC used for prediction lookup.
REQ-009 Port pred_taken  out  1: combinational prediction, MSB of counter[pc_f[IDX_W-1:0]].
REQ-010 Port br_valid  in  1: a conditional jump resolves this cycle.
REQ-011 Port br_cond  in  4: condition code of the resolving jump.
REQ-012 Port br_pc  in  PC_W: PC of the resolving jump.
REQ-013 Port br_pred  in  1: prediction originally issued for this jump.
REQ-014 Port res_valid  out  1: registered, br_valid delayed one cycle.
REQ-015 Port res_taken  out  1: registered evaluated outcome.
REQ-016 Port mispredict  out  1: registered single-cycle flush pulse.
REQ-017 Port br_count  out  16: resolved-branch counter.
REQ-018 Port mp_count  out  16: mispredict counter.

Function
REQ-019 Effective flags SHALL be cpsr_wdata when cpsr_we=1, else cpsr_out (same-cycle forwarding).
REQ-020 cpsr_out SHALL load cpsr_wdata on the clock edge after cpsr_we=1; otherwise it holds its value.
REQ-021 Condition codes SHALL be evaluated on the effective flags. 0 JMP always; 1 JEQ Z; 2 JNE !Z; 3 JGE N==V; 4 JGT !Z&&N==V; 5 JLE Z||N!=V; 6 JLT N!=V; 7 JCS C; 8 JCC !C; 9 JHI C&&!Z; 10 JLS !C||Z; 11 JMI N; 12 JPL !N; 13 JVS V; 14 JVC !V; 15 never.
REQ-022 The evaluated outcome SHALL be fully combinational and defined for every input, with no latch; it is 0 when br_valid=0.
REQ-023 Latency SHALL be one cycle: on the edge after br_valid=1, res_valid=1, res_taken=outcome, and mispredict=(outcome!=br_pred).
REQ-024 res_valid and mispredict SHALL be 0 in any cycle following br_valid=0; res_taken SHALL then be 0.
REQ-025 On br_valid=1, counter[br_pc[IDX_W-1:0]] SHALL increment if the outcome is taken (saturating at 3) and decrement if not taken (saturating at 0).
REQ-026 Each counter SHALL follow the states 0 SNT, 1 WNT, 2 WT, 3 ST; a counter predicts taken when it is 2 or 3.
REQ-027 Predictor index SHALL wrap: PC bits above IDX_W-1 are ignored, so aliasing PCs share a counter.
REQ-028 A lookup and an update to the same index in the same cycle SHALL return the pre-update value; the new value is visible from the next cycle.
REQ-029 br_count SHALL increment on each br_valid=1; mp_count SHALL increment on each mispredict condition; both saturate at 0xFFFF and never wrap.
REQ-030 Back-to-back br_valid on consecutive cycles SHALL each be resolved and counted, with no bubble.

Reset
REQ-031 While rst=1 at a clock edge, cpsr_out SHALL be 4'b0000; res_valid, res_taken and mispredict SHALL be 0; br_count and mp_count SHALL be 0; all counters SHALL be 1 (WNT).
REQ-032 Reset SHALL take priority over simultaneous cpsr_we or br_valid: that branch is dropped, with no counter update and no pulse.
REQ-033 With all counters at WNT after reset, pred_taken SHALL be 0 for any pc_f.

Verification
REQ-034 Set cpsr_we=1 with wdata=4'b0100 and, in the same cycle, br_valid=1, br_cond=1, br_pred=0 -> next cycle res_taken=1, mispredict=1, cpsr_out=4'b0100, mp_count=1.
REQ-035 With flags C=1, Z=0, issue br_cond=9 and then br_cond=10 -> res_taken is 1 and then 0; with N=1, V=0, issue br_cond=3 -> res_taken=0, and br_cond=6 -> res_taken=1.
REQ-036 Resolve br_pc=0x0005 as taken 3 times -> counter[5] steps 1->2->3->3; pred_taken for pc_f=0x0015 (alias when BHT_DEPTH=16) = 1.
REQ-037 Present the same index on pc_f and br_pc with counter=1 and a taken outcome -> pred_taken=0 that cycle and 1 the next cycle.
REQ-038 Preload br_count to 0xFFFE (force or drive 65534 branches), then issue 3 more -> br_count holds at 0xFFFF.
REQ-039 Assert rst while br_valid=1 in the middle of a stream -> the next cycle has res_valid=0 and both counters at 0, and pred_taken=0 everywhere.
